comp_sort4_ctrl: RTL

Sequencing controller that owns one 4-bit magnitude comparator (LG/EQ/RG outputs) and time-shares it to sort a burst of DEPTH 4-bit words.
- Words are accepted through a valid/ready input stream, held in an internal buffer and bubble-sorted with one compare per clock.
- Sorted words are emitted on a valid/ready output stream.
- Sits between a producer of unordered samples and any consumer needing ordered data; the comparator instance is internal and used only by this controller.

---
 rtl/comp_sort4_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/comp_sort4_ctrl.sv
// comp_sort4_ctrl: buffers a DEPTH-word burst, bubble-sorts it through one shared 4-bit comparator, then streams it out.
// Optional macro SORT_EARLY_EXIT_EN ends SORT after the first pass that makes no swap.
module comp4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic       lg,
   output logic       eq,
   output logic       rg
);
   assign lg = x > y;
   assign eq = x == y;
   assign rg = x < y;
endmodule

module comp_sort4_ctrl #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       DIR,
   input  logic       IN_VALID,
   output logic       IN_READY,
   input  logic [3:0] IN_DATA,
   output logic       OUT_VALID,
   input  logic       OUT_READY,
   output logic [3:0] OUT_DATA,
   output logic       OUT_LAST,
   output logic       BUSY
);
   typedef enum logic [1:0] {IDLE, LOAD, SORT, DRAIN} state_t;
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 2);
   localparam logic [CW-1:0] TOP  = CW'(DEPTH - 1);
   state_t        state;
   logic [3:0]    mem [2**CW];
   logic [CW-1:0] wr_idx, rd_idx, i, pass, ip1, nx_rd, nx_wr;
   logic          dir_q, lg, eq, rg, swap, done;
   logic [3:0]    first;
   assign ip1   = i + 1'b1;
   assign nx_rd = rd_idx + 1'b1;
   assign nx_wr = wr_idx + 1'b1;
   comp4 u_cmp (.x(mem[i]), .y(mem[ip1]), .lg(lg), .eq(eq), .rg(rg));
   assign swap  = !eq && (dir_q ? rg : lg);
   // the final compare may still move buf[0] when DEPTH is 2
   assign first = (swap && i == '0) ? mem[1] : mem[0];
`ifdef SORT_EARLY_EXIT_EN
   logic swp;
   assign done = pass == LAST || !((i == '0 ? 1'b0 : swp) | swap);
`else
   assign done = pass == LAST;
`endif
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= IDLE;
         IN_READY  <= 1'b1;
         OUT_VALID <= 1'b0;
         OUT_LAST  <= 1'b0;
         BUSY      <= 1'b0;
         OUT_DATA  <= '0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         i         <= '0;
         pass      <= '0;
         dir_q     <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
         swp       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (IN_VALID) begin
               mem[0] <= IN_DATA;
               dir_q  <= DIR;
               wr_idx <= CW'(1);
               state  <= LOAD;
            end
            LOAD: if (IN_VALID) begin
               mem[wr_idx] <= IN_DATA;
               wr_idx      <= nx_wr;
               if (wr_idx == TOP) begin
                  state    <= SORT;
                  IN_READY <= 1'b0;
                  BUSY     <= 1'b1;
                  pass     <= '0;
                  i        <= '0;
               end
            end
            SORT: begin
               if (swap) begin
                  mem[i]   <= mem[ip1];
                  mem[ip1] <= mem[i];
               end
`ifdef SORT_EARLY_EXIT_EN
               swp <= (i == '0 ? 1'b0 : swp) | swap;
`endif
               if (i == LAST) begin
                  i    <= '0;
                  pass <= pass + 1'b1;
                  if (done) begin
                     state     <= DRAIN;
                     OUT_VALID <= 1'b1;
                     OUT_DATA  <= first;
                     OUT_LAST  <= 1'b0;
                     rd_idx    <= '0;
                  end
               end else
                  i <= ip1;
            end
            DRAIN: if (OUT_READY) begin
               if (OUT_LAST) begin
                  state     <= IDLE;
                  OUT_VALID <= 1'b0;
                  OUT_LAST  <= 1'b0;
                  BUSY      <= 1'b0;
                  IN_READY  <= 1'b1;
               end else begin
                  rd_idx   <= nx_rd;
                  OUT_DATA <= mem[nx_rd];
                  OUT_LAST <= nx_rd == TOP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
